// File: rtl/ym_ssg_regs_if.sv
// Z80-side access bus for the SSG register bank.
// The CPU drives the strobes and write data. The bank returns the read data and the busy flag.
interface ym_ssg_regs_if;
  logic       WR;
  logic       RD;
  logic       A0;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       BUSY;

  modport master (output WR, RD, A0, DIN, input DOUT, BUSY);
  modport slave  (input WR, RD, A0, DIN, output DOUT, BUSY);
endinterface

// File: rtl/ym_ssg_regs.sv
// SSG register bank: address latch, register decode, read-back mux and post-write busy window.
// A write to the shape register produces a one-cycle ENV_RESTART strobe.
module ym_ssg_regs #(
  parameter int BUSY_CYCLES = 4
) (
  input  logic         PHI_S,
  input  logic         RESET,
  ym_ssg_regs_if.slave bus,
  output logic [11:0]  SSG_FREQ_A,
  output logic [11:0]  SSG_FREQ_B,
  output logic [11:0]  SSG_FREQ_C,
  output logic [4:0]   SSG_NOISE,
  output logic [5:0]   SSG_EN,
  output logic [4:0]   SSG_VOL_A,
  output logic [4:0]   SSG_VOL_B,
  output logic [4:0]   SSG_VOL_C,
  output logic [15:0]  SSG_ENV_FREQ,
  output logic [3:0]   SSG_ENV,
  output logic         ENV_RESTART
);

  logic [7:0]  addr_q,      addr_d;
  logic [11:0] freq_q [3];
  logic [11:0] freq_d [3];
  logic [4:0]  vol_q  [3];
  logic [4:0]  vol_d  [3];
  logic [4:0]  noise_q,     noise_d;
  logic [5:0]  en_q,        en_d;
  logic [15:0] env_freq_q,  env_freq_d;
  logic [3:0]  env_q,       env_d;
  logic        restart_q,   restart_d;
  logic [7:0]  busy_cnt_q,  busy_cnt_d;
  logic [7:0]  dout_q,      dout_d;

  logic       busy;
  logic       wr_accept;
  logic [7:0] rd_data;

  assign busy      = (busy_cnt_q != 8'd0);
  assign wr_accept = bus.WR && bus.A0 && !busy && (addr_q[7:4] == 4'd0);

  // Read-back value of the currently addressed register, zero-extended.
  always_comb begin
    rd_data = 8'h00;
    if (addr_q[7:4] == 4'd0) begin
      case (addr_q[3:0])
        4'h0:    rd_data = freq_q[0][7:0];
        4'h1:    rd_data = {4'h0, freq_q[0][11:8]};
        4'h2:    rd_data = freq_q[1][7:0];
        4'h3:    rd_data = {4'h0, freq_q[1][11:8]};
        4'h4:    rd_data = freq_q[2][7:0];
        4'h5:    rd_data = {4'h0, freq_q[2][11:8]};
        4'h6:    rd_data = {3'b000, noise_q};
        4'h7:    rd_data = {2'b00, en_q};
        4'h8:    rd_data = {3'b000, vol_q[0]};
        4'h9:    rd_data = {3'b000, vol_q[1]};
        4'hA:    rd_data = {3'b000, vol_q[2]};
        4'hB:    rd_data = env_freq_q[7:0];
        4'hC:    rd_data = env_freq_q[15:8];
        4'hD:    rd_data = {4'h0, env_q};
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    addr_d     = addr_q;
    freq_d     = freq_q;
    vol_d      = vol_q;
    noise_d    = noise_q;
    en_d       = en_q;
    env_freq_d = env_freq_q;
    env_d      = env_q;
    restart_d  = 1'b0;
    dout_d     = dout_q;
    busy_cnt_d = busy ? busy_cnt_q - 8'd1 : busy_cnt_q;

    if (bus.WR) begin
      if (!bus.A0) begin
        addr_d = bus.DIN;
      end else if (wr_accept) begin
        busy_cnt_d = 8'(BUSY_CYCLES);
        for (int ch = 0; ch < 3; ch++) begin
          if (addr_q[3:0] == 4'(2 * ch))     freq_d[ch][7:0]  = bus.DIN;
          if (addr_q[3:0] == 4'(2 * ch + 1)) freq_d[ch][11:8] = bus.DIN[3:0];
          if (addr_q[3:0] == 4'(8 + ch))     vol_d[ch]        = bus.DIN[4:0];
        end
        case (addr_q[3:0])
          4'h6:    noise_d           = bus.DIN[4:0];
          4'h7:    en_d              = bus.DIN[5:0];
          4'hB:    env_freq_d[7:0]   = bus.DIN;
          4'hC:    env_freq_d[15:8]  = bus.DIN;
          4'hD: begin
            env_d     = bus.DIN[3:0];
            restart_d = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (bus.RD) begin
      dout_d = bus.A0 ? rd_data : {busy, 7'b0000000};
    end
  end

  always_ff @(posedge PHI_S or posedge RESET) begin
    if (RESET) begin
      addr_q     <= 8'h00;
      for (int ch = 0; ch < 3; ch++) begin
        freq_q[ch] <= 12'h000;
        vol_q[ch]  <= 5'h00;
      end
      noise_q    <= 5'h00;
      en_q       <= 6'h00;
      env_freq_q <= 16'h0000;
      env_q      <= 4'h0;
      restart_q  <= 1'b0;
      busy_cnt_q <= 8'h00;
      dout_q     <= 8'h00;
    end else begin
      addr_q     <= addr_d;
      freq_q     <= freq_d;
      vol_q      <= vol_d;
      noise_q    <= noise_d;
      en_q       <= en_d;
      env_freq_q <= env_freq_d;
      env_q      <= env_d;
      restart_q  <= restart_d;
      busy_cnt_q <= busy_cnt_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.DOUT     = dout_q;
  assign bus.BUSY     = busy;
  assign SSG_FREQ_A   = freq_q[0];
  assign SSG_FREQ_B   = freq_q[1];
  assign SSG_FREQ_C   = freq_q[2];
  assign SSG_NOISE    = noise_q;
  assign SSG_EN       = en_q;
  assign SSG_VOL_A    = vol_q[0];
  assign SSG_VOL_B    = vol_q[1];
  assign SSG_VOL_C    = vol_q[2];
  assign SSG_ENV_FREQ = env_freq_q;
  assign SSG_ENV      = env_q;
  assign ENV_RESTART  = restart_q;

endmodule

// File: tb/tb_ym_ssg_regs.sv
// Directed bench for ym_ssg_regs: a vector table of accesses with expected results,
// followed by hand-written sequences for the busy window, the restart strobe and reset.
module tb_ym_ssg_regs;

  logic PHI_S = 1'b0;
  logic RESET = 1'b1;
  logic [11:0] freq_a, freq_b, freq_c;
  logic [4:0]  noise, vol_a, vol_b, vol_c;
  logic [5:0]  en;
  logic [15:0] env_freq;
  logic [3:0]  env;
  logic        env_restart;

  ym_ssg_regs_if bus ();

  ym_ssg_regs #(.BUSY_CYCLES(4)) dut (
    .PHI_S        (PHI_S),
    .RESET        (RESET),
    .bus          (bus.slave),
    .SSG_FREQ_A   (freq_a),
    .SSG_FREQ_B   (freq_b),
    .SSG_FREQ_C   (freq_c),
    .SSG_NOISE    (noise),
    .SSG_EN       (en),
    .SSG_VOL_A    (vol_a),
    .SSG_VOL_B    (vol_b),
    .SSG_VOL_C    (vol_c),
    .SSG_ENV_FREQ (env_freq),
    .SSG_ENV      (env),
    .ENV_RESTART  (env_restart)
  );

  always #5 PHI_S = ~PHI_S;

  typedef enum int {C_NONE, C_DOUT, C_FA, C_FB, C_FC, C_NOISE, C_EN,
                    C_VA, C_VB, C_VC, C_EF, C_ENV, C_BUSY} chk_e;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        a0;
    logic [7:0]  din;
    int          wait_cyc;
    chk_e        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [40];
  int   n_vec = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic logic [15:0] observe(chk_e c);
    case (c)
      C_DOUT:  return {8'h00, bus.DOUT};
      C_FA:    return {4'h0, freq_a};
      C_FB:    return {4'h0, freq_b};
      C_FC:    return {4'h0, freq_c};
      C_NOISE: return {11'h000, noise};
      C_EN:    return {10'h000, en};
      C_VA:    return {11'h000, vol_a};
      C_VB:    return {11'h000, vol_b};
      C_VC:    return {11'h000, vol_c};
      C_EF:    return env_freq;
      C_ENV:   return {12'h000, env};
      C_BUSY:  return {15'h0000, bus.BUSY};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge PHI_S);
    #1;
  endtask

  task automatic access(input logic w, input logic r, input logic a0, input logic [7:0] d);
    bus.WR  = w;
    bus.RD  = r;
    bus.A0  = a0;
    bus.DIN = d;
    tick();
    bus.WR  = 1'b0;
    bus.RD  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_not_busy();
    int k;
    k = 0;
    while (bus.BUSY && k < 20) begin
      tick();
      k++;
    end
    check("busy_clear_timeout", {15'h0, bus.BUSY}, 16'h0000);
  endtask

  task automatic add(input logic w, input logic r, input logic a0, input logic [7:0] d,
                     input int wc, input chk_e c, input logic [15:0] e);
    vecs[n_vec] = '{w, r, a0, d, wc, c, e};
    n_vec++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freq_a"}, {4'h0, freq_a}, 16'h0);
    check({tag, "_freq_b"}, {4'h0, freq_b}, 16'h0);
    check({tag, "_freq_c"}, {4'h0, freq_c}, 16'h0);
    check({tag, "_misc"}, {noise, vol_a, vol_b, 1'b0}, 16'h0);
    check({tag, "_en_volc"}, {5'h0, en, vol_c}, 16'h0);
    check({tag, "_env_freq"}, env_freq, 16'h0);
    check({tag, "_env_rst_busy"}, {10'h0, env, env_restart, bus.BUSY}, 16'h0);
    check({tag, "_dout"}, {8'h0, bus.DOUT}, 16'h0);
  endtask

  initial begin
    bus.WR = 1'b0; bus.RD = 1'b0; bus.A0 = 1'b0; bus.DIN = 8'h00;

    // Vector table: access, optional check right after its edge, then idle cycles.
    add(1, 0, 0, 8'h02, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h34, 4, C_FB,    16'h0034);
    add(1, 0, 0, 8'h03, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'hF7, 4, C_FB,    16'h0734);
    add(1, 0, 0, 8'h04, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h99, 4, C_FC,    16'h0099);
    add(1, 0, 0, 8'h05, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h0A, 4, C_FC,    16'h0A99);
    add(1, 0, 0, 8'h08, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'hF3, 4, C_VA,    16'h0013);
    add(1, 0, 0, 8'h09, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h1F, 4, C_VB,    16'h001F);
    add(1, 0, 0, 8'h0A, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h05, 4, C_VC,    16'h0005);
    add(1, 0, 0, 8'h0B, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h34, 4, C_EF,    16'h0034);
    add(1, 0, 0, 8'h0C, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h12, 4, C_EF,    16'h1234);
    add(0, 1, 1, 8'h00, 0, C_DOUT,  16'h0012);
    add(1, 0, 0, 8'h05, 0, C_NONE,  16'h0000);
    add(0, 1, 1, 8'h00, 0, C_DOUT,  16'h000A);
    add(1, 0, 0, 8'h08, 0, C_NONE,  16'h0000);
    add(0, 1, 1, 8'h00, 0, C_DOUT,  16'h0013);
    add(1, 0, 0, 8'h03, 0, C_NONE,  16'h0000);
    add(0, 1, 1, 8'h00, 0, C_DOUT,  16'h0007);
    add(1, 0, 0, 8'h0E, 0, C_NONE,  16'h0000);
    add(0, 1, 1, 8'h00, 0, C_DOUT,  16'h0000);
    add(1, 0, 0, 8'h10, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h55, 0, C_BUSY,  16'h0000);
    add(0, 0, 0, 8'h00, 0, C_FA,    16'h0000);
    add(0, 1, 1, 8'h00, 0, C_DOUT,  16'h0000);
    add(1, 0, 0, 8'h0F, 0, C_NONE,  16'h0000);
    add(1, 0, 1, 8'h12, 4, C_BUSY,  16'h0001);

    // Reset state
    idle(2);
    RESET = 1'b0;
    tick();
    check_all_zero("reset");
    access(0, 1, 0, 8'h00);
    check("reset_status", {8'h0, bus.DOUT}, 16'h0000);

    for (int i = 0; i < n_vec; i++) begin
      access(vecs[i].wr, vecs[i].rd, vecs[i].a0, vecs[i].din);
      if (vecs[i].chk != C_NONE)
        check($sformatf("vec%0d", i), observe(vecs[i].chk), vecs[i].exp);
      idle(vecs[i].wait_cyc);
    end

    // Tone write: BUSY high for exactly four cycles after the data write
    access(1, 0, 0, 8'h01);
    access(1, 0, 1, 8'hAB);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("busy_cycle%0d", c), {15'h0, bus.BUSY}, 16'h0001);
      tick();
    end
    check("busy_cycle5", {15'h0, bus.BUSY}, 16'h0000);
    access(1, 0, 0, 8'h00);
    access(1, 0, 1, 8'hCD);
    check("tone_freq_a", {4'h0, freq_a}, 16'h0BCD);
    idle(4);

    // Busy drop and status reads during and after the window
    access(1, 0, 0, 8'h06);
    access(1, 0, 1, 8'h1F);
    access(1, 0, 1, 8'h05);
    access(0, 1, 0, 8'h00);
    check("status_busy", {8'h0, bus.DOUT}, 16'h0080);
    wait_not_busy();
    check("noise_kept", {11'h0, noise}, 16'h001F);
    access(0, 1, 0, 8'h00);
    check("status_idle", {8'h0, bus.DOUT}, 16'h0000);

    // Boundary: write at edge N+4 is dropped, at edge N+5 accepted
    access(1, 0, 1, 8'h11);
    idle(3);
    access(1, 0, 1, 8'h02);
    check("edge_n4_dropped", {11'h0, noise}, 16'h0011);
    access(1, 0, 1, 8'h03);
    check("edge_n5_accepted", {11'h0, noise}, 16'h0003);
    idle(4);

    // Envelope restart pulses, including a repeated identical write
    access(1, 0, 0, 8'h0D);
    check("env_restart_idle", {15'h0, env_restart}, 16'h0000);
    for (int r = 0; r < 2; r++) begin
      access(1, 0, 1, 8'hFE);
      check($sformatf("env_shape%0d", r), {12'h0, env}, 16'h000E);
      check($sformatf("env_pulse_hi%0d", r), {15'h0, env_restart}, 16'h0001);
      tick();
      check($sformatf("env_pulse_lo%0d", r), {15'h0, env_restart}, 16'h0000);
      idle(3);
    end
    access(0, 1, 1, 8'h00);
    check("env_readback", {8'h0, bus.DOUT}, 16'h000E);

    // Mixer masking and read-after-write ordering
    access(1, 0, 0, 8'h07);
    access(1, 0, 1, 8'hFF);
    access(0, 1, 1, 8'h00);
    check("en_read_after_write", {8'h0, bus.DOUT}, 16'h003F);
    check("en_out", {10'h0, en}, 16'h003F);
    idle(3);

    // Collision: WR wins, DOUT held; address change during busy retargets the next write
    access(1, 1, 1, 8'h2A);
    check("collide_en", {10'h0, en}, 16'h002A);
    check("collide_dout", {8'h0, bus.DOUT}, 16'h003F);
    access(1, 0, 0, 8'h02);
    wait_not_busy();
    access(1, 0, 1, 8'h66);
    check("retarget_freq_b", {4'h0, freq_b}, 16'h0766);
    check("retarget_en_kept", {10'h0, en}, 16'h002A);

    // Asynchronous reset in the middle of a busy window and a restart pulse
    access(1, 0, 0, 8'h0D);
    idle(3);
    access(1, 0, 1, 8'h09);
    #2 RESET = 1'b1;
    #1;
    check_all_zero("async");
    #1 RESET = 1'b0;
    tick();
    access(1, 0, 0, 8'h00);
    access(1, 0, 1, 8'h11);
    check("post_reset_write", {4'h0, freq_a}, 16'h0011);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
